// File: rtl/wb_commit.sv
// Writeback commit unit: merges single-cycle ALU results with buffered load
// results and issues at most one register-file write per cycle. A load whose
// destination is overwritten by a younger ALU result is killed in the FIFO.
module wb_commit #(
  parameter  int unsigned DEPTH        = 4,
  parameter  int unsigned STARVE_MAX   = 8,
  localparam int unsigned REG_NUM      = 5,
  localparam int unsigned COMMON_WIDTH = 32,
  localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [REG_NUM-1:0]      alu_rd,
  input  logic [COMMON_WIDTH-1:0] alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [REG_NUM-1:0]      mem_rd,
  input  logic [COMMON_WIDTH-1:0] mem_data,
  output logic [REG_NUM-1:0]      reg_write,
  output logic [COMMON_WIDTH-1:0] data_write,
  output logic [CNT_W-1:0]        fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  // One buffered load result; live is cleared when a younger ALU write
  // targets the same register.
  typedef struct packed {
    logic [REG_NUM-1:0]      rd;
    logic [COMMON_WIDTH-1:0] data;
    logic                    live;
  } entry_t;

  entry_t                  fifo_q   [DEPTH];
  entry_t                  fifo_nxt [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_nxt;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]        count_q, count_nxt;
  logic [STV_W-1:0]        starve_q, starve_nxt;
  logic [REG_NUM-1:0]      reg_write_q, reg_write_nxt;
  logic [COMMON_WIDTH-1:0] data_write_q, data_write_nxt;

  entry_t head;
  logic   fifo_empty;
  logic   starved;
  logic   alu_acc;
  logic   alu_wins;
  logic   push;
  logic   pop;

  // Handshake and arbitration terms; readys depend only on registered state.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    starved    = (starve_q == STV_W'(STARVE_MAX)) && !fifo_empty;
    alu_ready  = rst && !starved;
    mem_ready  = rst && (count_q != CNT_W'(DEPTH));
    alu_acc    = alu_valid && alu_ready;
    push       = mem_valid && mem_ready;
    alu_wins   = alu_acc && (alu_rd != '0);
    pop        = !alu_wins && !fifo_empty;
  end

  // FIFO contents: kill same-rd entries on an ALU write, then store the push.
  always_comb begin
    fifo_nxt = fifo_q;
    if (alu_wins) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (fifo_q[PTR_W'(i)].rd == alu_rd) begin
          fifo_nxt[PTR_W'(i)].live = 1'b0;
        end
      end
    end
    if (push) begin
      fifo_nxt[wr_ptr_q].rd   = mem_rd;
      fifo_nxt[wr_ptr_q].data = mem_data;
      fifo_nxt[wr_ptr_q].live = !(alu_wins && (mem_rd == alu_rd));
    end
  end

  // Pointer, occupancy and starvation bookkeeping.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    starve_nxt = starve_q;
    if (push) begin
      wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
    if (fifo_empty || pop) begin
      starve_nxt = '0;
    end else if (alu_wins) begin
      starve_nxt = starve_q + STV_W'(1);
    end
  end

  // Write-port selection: ALU first, else FIFO head; killed or rd=0 heads drop.
  always_comb begin
    reg_write_nxt  = '0;
    data_write_nxt = data_write_q;
    if (alu_wins) begin
      reg_write_nxt  = alu_rd;
      data_write_nxt = alu_data;
    end else if (pop && head.live && (head.rd != '0)) begin
      reg_write_nxt  = head.rd;
      data_write_nxt = head.data;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
    end else begin
      fifo_q       <= fifo_nxt;
      wr_ptr_q     <= wr_ptr_nxt;
      rd_ptr_q     <= rd_ptr_nxt;
      count_q      <= count_nxt;
      starve_q     <= starve_nxt;
      reg_write_q  <= reg_write_nxt;
      data_write_q <= data_write_nxt;
    end
  end

  assign reg_write  = reg_write_q;
  assign data_write = data_write_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed testbench for wb_commit: reset, ALU path, FIFO fill/drain,
// ordering kill, starvation hold-off and asynchronous mid-stream reset.
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [4:0]  reg_write;
  logic [31:0] data_write;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] shadow [32];

  wb_commit #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .data_write (data_write),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file image built from the observed write port.
  always @(posedge clk) begin
    if (rst && reg_write != 5'd0) shadow[reg_write] <= data_write;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    idle_inputs();

    // Reset and idle
    rst = 1'b0;
    step(); step(); step();
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_data_write", data_write, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_alu_ready", 32'(alu_ready), 32'd1);
    chk("rel_mem_ready", 32'(mem_ready), 32'd1);
    step();
    chk("idle_reg_write", 32'(reg_write), 32'd0);

    // ALU path: one-cycle write, then rd=0 produces nothing
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_rd3", 32'(reg_write), 32'd3);
    chk("alu_data3", data_write, 32'hDEADBEEF);
    idle_inputs();
    step();
    chk("alu_one_cycle", 32'(reg_write), 32'd0);
    chk("alu_data_hold", data_write, 32'hDEADBEEF);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    step();
    chk("alu_rd0", 32'(reg_write), 32'd0);
    chk("alu_rd0_data", data_write, 32'hDEADBEEF);
    idle_inputs();

    // Fill FIFO behind a busy ALU, then drain in order
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(k + 1); mem_data = 32'h10 + 32'(k);
      step();
      chk("fill_alu_wr", 32'(reg_write), 32'd7);
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_mem_ready", 32'(mem_ready), 32'd0);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_rd", 32'(reg_write), 32'(k + 1));
      chk("drain_data", data_write, 32'h10 + 32'(k));
      if (k == 0) chk("drain_mem_ready", 32'(mem_ready), 32'd1);
    end
    chk("drain_count", 32'(fifo_count), 32'd0);
    step();
    chk("drain_idle", 32'(reg_write), 32'd0);

    // Load latency: push at edge N, write visible in cycle N+2
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    step();
    idle_inputs();
    chk("load_lat_n1", 32'(reg_write), 32'd0);
    step();
    chk("load_lat_n2", 32'(reg_write), 32'd6);
    chk("load_lat_data", data_write, 32'h66);

    // Ordering kill of a buffered load
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hAA;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hBB;
    step();
    chk("kill_alu_rd", 32'(reg_write), 32'd5);
    chk("kill_alu_data", data_write, 32'hBB);
    chk("kill_count", 32'(fifo_count), 32'd1);
    idle_inputs();
    step();
    chk("kill_drop", 32'(reg_write), 32'd0);
    chk("kill_count0", 32'(fifo_count), 32'd0);
    step();
    chk("kill_r5", shadow[5], 32'hBB);

    // Same-cycle push and ALU write to the same register
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hC2;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'hC1;
    step();
    chk("samecyc_rd", 32'(reg_write), 32'd8);
    chk("samecyc_data", data_write, 32'hC2);
    idle_inputs();
    step();
    chk("samecyc_drop", 32'(reg_write), 32'd0);
    step();
    chk("samecyc_r8", shadow[8], 32'hC2);

    // Starvation: 8 ALU wins, then one forced pop
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h5A;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("starve_alu_wr", 32'(reg_write), 32'd9);
      chk("starve_ready", 32'(alu_ready), 32'd1);
    end
    step();
    chk("starve_8th_wr", 32'(reg_write), 32'd9);
    chk("starve_hold", 32'(alu_ready), 32'd0);
    step();
    chk("starve_pop_rd", 32'(reg_write), 32'd10);
    chk("starve_pop_data", data_write, 32'h5A);
    chk("starve_ready_back", 32'(alu_ready), 32'd1);
    step();
    chk("starve_alu_again", 32'(reg_write), 32'd9);
    idle_inputs();
    step();

    // Asynchronous reset with three loads buffered
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(k + 11); mem_data = 32'h20 + 32'(k);
      step();
    end
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    idle_inputs();
    #1;
    rst = 1'b0;
    #1;
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_reg_write", 32'(reg_write), 32'd0);
    chk("async_alu_ready", 32'(alu_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_wr1", 32'(reg_write), 32'd0);
    step();
    chk("post_rst_wr2", 32'(reg_write), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit: the write side of the ID-stage register file. It merges single-cycle ALU results with buffered multi-cycle load results and issues at most one register write per cycle on the `reg_write`/`data_write` pair that the register file consumes. It sits between EX/MEM and ID, buffering load results in a small FIFO and keeping write ordering correct per destination register.

## Interface
- `DEPTH`, 4: load-result FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 8: consecutive cycles a non-empty FIFO head may lose to the ALU before the ALU is held off.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle when high.
- `alu_rd`  in  `REG_NUM` (5)  ALU destination.
- `alu_data`  in  `COMMON_WIDTH` (32)  ALU result.
- `mem_valid`  in  1  load result present.
- `mem_ready`  out  1  FIFO not full.
- `mem_rd`  in  5  load destination.
- `mem_data`  in  32  load data.
- `reg_write`  out  5  register to write; 0 means no write.
- `data_write`  out  32  write data.
- `fifo_count`  out  clog2(DEPTH)+1  occupied FIFO entries.

## Operation
- ALU accept: `alu_valid && alu_ready`. Load push: `mem_valid && mem_ready`; `mem_ready = rst && (fifo_count != DEPTH)`.
- FIFO entry = {rd, data, live}. Push writes `live=1`.
- Per-cycle selection, one write max:
  - ALU accepted with `alu_rd != 0` → register output {alu_rd, alu_data}.
  - Else if FIFO non-empty → pop head; if head live and rd != 0 → output {rd, data}, else output rd=0 (silent drop).
  - Else output rd=0; `data_write` holds its previous value.
- ALU accept with `alu_rd == 0` does not block the FIFO; the head pops the same cycle.
- Ordering kill: an ALU accept with `alu_rd != 0` clears `live` on every FIFO entry whose rd equals `alu_rd`, including an entry pushed in the same cycle. A stale load never overwrites a newer ALU result.
- Starvation counter: increments each cycle the FIFO is non-empty and the ALU wins the write; clears on any pop or when the FIFO is empty. When counter == STARVE_MAX and FIFO non-empty → `alu_ready=0` for that cycle; the head pops; counter clears. Otherwise `alu_ready = rst`.
- Simultaneous push and pop: count unchanged; push allowed when full only if… not allowed: `mem_ready` is based on current count, no same-cycle credit.
- Pointers wrap modulo DEPTH; count saturates naturally at DEPTH via `mem_ready`.

## Timing
- Reset (rst low, async): `reg_write=0`, `data_write=0`, FIFO empty, `fifo_count=0`, starvation counter 0, `alu_ready=0`, `mem_ready=0`. Both readys rise combinationally when rst deasserts.
- ALU latency: accept at edge N → `reg_write/data_write` valid during cycle N+1, held exactly one cycle.
- Load latency: push at edge N → earliest write visible cycle N+2 (no bypass).
- `alu_ready` and `mem_ready` are combinational from registered state only, with no input-to-ready path.
- Reset mid-operation clears all FIFO contents; buffered loads are lost, and no write issues in the cycle after release unless an accept occurs.

## Test plan
- Reset/idle: hold rst low 3 cycles → all outputs 0; release with no valids → `reg_write` stays 0, `alu_ready=mem_ready=1`.
- ALU path: alu {rd=3, 0xDEADBEEF} at edge N → `reg_write=3`, `data_write=0xDEADBEEF` in cycle N+1 only; rd=0 input → `reg_write` stays 0.
- FIFO full/drain: push 4 loads (rd 1..4, data 0x10..0x13) while ALU busy to rd 7 → `mem_ready=0`, `fifo_count=4`; drop ALU → writes 1..4 in order on consecutive cycles; `mem_ready` returns after the first pop.
- Ordering kill: load rd=5 data 0xAA buffered; ALU rd=5 data 0xBB → 0xBB written; the later pop of the rd=5 entry produces `reg_write=0`; final r5 value is 0xBB.
- Starvation: one load queued, ALU valid every cycle with rd=9 → after 8 ALU writes, `alu_ready=0` for one cycle and the load is written; then `alu_ready` returns to 1.
- Async reset mid-stream: assert rst with `fifo_count=3` → count 0 and `reg_write=0` immediately, without waiting for a clock edge; no stale writes after release.
